waveform_burst_sequencer: RTL and testbench

- Sequences one PWM/triangle waveform generator through a programmed burst train.
- Each burst is one trigger pulse to the generator, followed by a wait for the generator to finish its active window, then a programmable gap. This repeats for a programmed number of bursts.
- Sits between the host/register interface and the generator's control FSM.
- Supplies the per-burst duration and supervises generator acknowledgement with a timeout.

---
 rtl/waveform_burst_sequencer_if.sv | 38 +++
 rtl/waveform_burst_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_waveform_burst_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/waveform_burst_sequencer_if.sv
// Purpose : host/generator-facing signal bundle for waveform_burst_sequencer.
// Latency : n/a (wires only).
// Backpressure: none; the generator's gen_active is the only flow signal.
// Ports (master = host + generator side, slave = sequencer side):
//   start, abort, burst_count, gap_cycles, duration : host -> sequencer
//   gen_active                                      : generator -> sequencer
//   trigger_pulse, duration_out                     : sequencer -> generator
//   busy, bursts_done, done, aborted, err           : sequencer -> host
interface waveform_burst_sequencer_if #(
  parameter int C = 8,
  parameter int G = 16,
  parameter int D = 8
);
  logic         start;
  logic         abort;
  logic [C-1:0] burst_count;
  logic [G-1:0] gap_cycles;
  logic [D-1:0] duration;
  logic         gen_active;

  logic         trigger_pulse;
  logic [D-1:0] duration_out;
  logic         busy;
  logic [C-1:0] bursts_done;
  logic         done;
  logic         aborted;
  logic         err;

  modport master (
    output start, abort, burst_count, gap_cycles, duration, gen_active,
    input  trigger_pulse, duration_out, busy, bursts_done, done, aborted, err
  );

  modport slave (
    input  start, abort, burst_count, gap_cycles, duration, gen_active,
    output trigger_pulse, duration_out, busy, bursts_done, done, aborted, err
  );
endinterface

// File: rtl/waveform_burst_sequencer.sv
// Purpose : drives one waveform generator through a programmed train of bursts
//           (trigger, wait for active window, programmable gap, repeat).
// Latency : start sampled in cycle N -> trigger_pulse in N+1; done/aborted are
//           registered one-cycle pulses after the deciding cycle.
// Backpressure: start is ignored while busy; the generator paces the train via
//           gen_active, with an ack timeout guarding a dead generator.
// Ports: clk, rst (sync, active-high) plus the bus interface (slave modport):
//   start/abort/burst_count/gap_cycles/duration/gen_active in,
//   trigger_pulse/duration_out/busy/bursts_done/done/aborted/err out.
module waveform_burst_sequencer #(
  parameter int C           = 8,
  parameter int G           = 16,
  parameter int D           = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  waveform_burst_sequencer_if.slave    bus
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ACT,
    WAIT_DONE,
    GAP
  } state_t;

  state_t state;
  state_t state_nxt;

  // Configuration latched on an accepted start; host inputs are ignored while busy.
  logic [C-1:0]  count_lat;
  logic [G-1:0]  gap_lat;
  logic [D-1:0]  dur_q;

  logic [G-1:0]  gap_cnt;
  logic [AW-1:0] ack_cnt;
  logic [C-1:0]  bursts_q;
  logic [C-1:0]  bursts_inc;
  logic          done_q;
  logic          aborted_q;
  logic          err_q;

  // Datapath strobes produced by the next-state logic.
  logic cfg_load;
  logic stats_clr;
  logic err_set;
  logic bursts_upd;
  logic gap_load;
  logic ack_clr;
  logic ack_inc;
  logic done_set;
  logic aborted_set;

  assign bursts_inc = bursts_q + C'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_nxt   = state;
    cfg_load    = 1'b0;
    stats_clr   = 1'b0;
    err_set     = 1'b0;
    bursts_upd  = 1'b0;
    gap_load    = 1'b0;
    ack_clr     = 1'b0;
    ack_inc     = 1'b0;
    done_set    = 1'b0;
    aborted_set = 1'b0;

    case (state)
      IDLE: begin
        // abort is meaningless here, so start wins even if both arrive together.
        if (bus.start) begin
          stats_clr = 1'b1;
          if (bus.burst_count != '0) begin
            cfg_load  = 1'b1;
            state_nxt = TRIG;
          end else begin
            // Empty train: report completion without touching the generator.
            done_set = 1'b1;
          end
        end
      end

      TRIG: begin
        ack_clr   = 1'b1;
        state_nxt = WAIT_ACT;
      end

      WAIT_ACT: begin
        if (bus.gen_active) begin
          state_nxt = WAIT_DONE;
        end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
          // Last allowed cycle without an ack: give up, keep bursts_done as is.
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          ack_inc = 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!bus.gen_active) begin
          bursts_upd = 1'b1;
          if (bursts_inc == count_lat) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else if (gap_lat == '0) begin
            state_nxt = TRIG;
          end else begin
            gap_load  = 1'b1;
            state_nxt = GAP;
          end
        end
      end

      GAP: begin
        // gap_cnt is loaded with the gap length, so leaving at 1 gives exactly
        // gap_lat cycles in this state.
        if (gap_cnt == G'(1)) begin
          state_nxt = TRIG;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // abort pre-empts every transition and side effect outside IDLE.
    if ((state != IDLE) && bus.abort) begin
      state_nxt   = IDLE;
      err_set     = 1'b0;
      bursts_upd  = 1'b0;
      done_set    = 1'b0;
      gap_load    = 1'b0;
      ack_clr     = 1'b0;
      ack_inc     = 1'b0;
      aborted_set = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_lat <= '0;
      gap_lat   <= '0;
      dur_q     <= '0;
      gap_cnt   <= '0;
      ack_cnt   <= '0;
      bursts_q  <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q    <= done_set;
      aborted_q <= aborted_set;

      if (cfg_load) begin
        count_lat <= bus.burst_count;
        gap_lat   <= bus.gap_cycles;
        dur_q     <= bus.duration;
      end

      if (stats_clr) begin
        bursts_q <= '0;
        err_q    <= 1'b0;
      end else begin
        if (err_set) begin
          err_q <= 1'b1;
        end
        if (bursts_upd) begin
          bursts_q <= bursts_inc;
        end
      end

      if (ack_clr) begin
        ack_cnt <= '0;
      end else if (ack_inc) begin
        ack_cnt <= ack_cnt + AW'(1);
      end

      if (gap_load) begin
        gap_cnt <= gap_lat;
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - G'(1);
      end
    end
  end

  // Outputs
  assign bus.trigger_pulse = (state == TRIG) && !bus.abort;
  assign bus.duration_out  = dur_q;
  assign bus.busy          = (state != IDLE);
  assign bus.bursts_done   = bursts_q;
  assign bus.done          = done_q;
  assign bus.aborted       = aborted_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_waveform_burst_sequencer.sv
module tb_waveform_burst_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  waveform_burst_sequencer_if #(.C(8), .G(16), .D(8)) bus();

  waveform_burst_sequencer #(
    .C(8), .G(16), .D(8), .ACK_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Generator model: gen_active rises the cycle after a trigger and stays
  // high for gen_hold cycles; gen_dead models a generator that never answers.
  int gen_hold = 6;
  bit gen_dead = 1'b0;
  int gen_cnt  = 0;

  always @(posedge clk) begin
    if (rst || gen_dead) begin
      bus.gen_active <= 1'b0;
      gen_cnt        <= 0;
    end else if (bus.trigger_pulse) begin
      bus.gen_active <= 1'b1;
      gen_cnt        <= gen_hold - 1;
    end else if (gen_cnt != 0) begin
      gen_cnt <= gen_cnt - 1;
    end else begin
      bus.gen_active <= 1'b0;
    end
  end

  typedef struct {
    int count;
    int gap;
    int dur;
    int hold;
    int dead;
    int exp_trigs;
    int exp_t1;     // cycle of first trigger (start driven in cycle 0)
    int exp_t2;     // cycle of second trigger, 0 if none
    int exp_end;    // cycle in which done or err is first seen
    int exp_bursts;
    int exp_done;
    int exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, " trigger_pulse"}, int'(bus.trigger_pulse), 0);
    check({pfx, " duration_out"},  int'(bus.duration_out), 0);
    check({pfx, " busy"},          int'(bus.busy), 0);
    check({pfx, " bursts_done"},   int'(bus.bursts_done), 0);
    check({pfx, " done"},          int'(bus.done), 0);
    check({pfx, " aborted"},       int'(bus.aborted), 0);
    check({pfx, " err"},           int'(bus.err), 0);
  endtask

  task automatic run_row(input vec_t v, input int idx);
    int trigs, t1, t2, endc, busy1, err1;
    string p;
    p        = $sformatf("row%0d", idx);
    gen_hold = v.hold;
    gen_dead = (v.dead != 0);
    bus.burst_count = 8'(v.count);
    bus.gap_cycles  = 16'(v.gap);
    bus.duration    = 8'(v.dur);
    bus.start       = 1'b1;
    trigs = 0; t1 = 0; t2 = 0; endc = 0; busy1 = 0; err1 = 1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k == 1) begin
        bus.start = 1'b0;
        busy1 = int'(bus.busy);
        err1  = int'(bus.err);
      end
      if (bus.trigger_pulse) begin
        trigs++;
        if (trigs == 1) t1 = k;
        else if (trigs == 2) t2 = k;
      end
      if (bus.done || bus.err || bus.aborted) begin
        endc = k;
        break;
      end
    end
    check({p, " busy_c1"},      busy1, 1);
    check({p, " err_c1"},       err1, 0);
    check({p, " trig_count"},   trigs, v.exp_trigs);
    check({p, " trig1_cycle"},  t1, v.exp_t1);
    check({p, " trig2_cycle"},  t2, v.exp_t2);
    check({p, " end_cycle"},    endc, v.exp_end);
    check({p, " bursts_done"},  int'(bus.bursts_done), v.exp_bursts);
    check({p, " done"},         int'(bus.done), v.exp_done);
    check({p, " err"},          int'(bus.err), v.exp_err);
    check({p, " aborted"},      int'(bus.aborted), 0);
    check({p, " busy_end"},     int'(bus.busy), 0);
    check({p, " duration_out"}, int'(bus.duration_out), v.dur);
    step();
    check({p, " done_1cyc"},    int'(bus.done), 0);
    gen_dead = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    int trigs, t2, busy_seen, dones, extra_trig, extra_done, extra_ab;

    //          cnt gap dur hold dead trg t1 t2 end bd done err
    vecs[0] = '{1,  0,  5,  6,   0,   1,  1, 0,  9, 1, 1,   0};  // single burst
    vecs[1] = '{3,  4,  7,  6,   0,   3,  1, 13, 33, 3, 1,  0};  // gap of 4
    vecs[2] = '{2,  0,  2,  6,   0,   2,  1, 9,  17, 2, 1,  0};  // back-to-back
    vecs[3] = '{2,  0,  4,  0,   1,   1,  1, 0,  6,  0, 0,  1};  // ack timeout
    vecs[4] = '{2,  1,  8,  2,   0,   2,  1, 6,  10, 2, 1,  0};  // clears err, gap 1
    vecs[5] = '{1,  0,  1,  1,   0,   1,  1, 0,  4,  1, 1,  0};  // 1-cycle active

    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.burst_count = '0;
    bus.gap_cycles  = '0;
    bus.duration    = '0;
    rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      run_row(vecs[i], i);
    end

    // start with count=0: immediate done, generator untouched.
    bus.burst_count = 8'd0;
    bus.duration    = 8'd9;
    bus.start       = 1'b1;
    trigs = 0; busy_seen = 0; dones = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) begin
        bus.start = 1'b0;
        check("cnt0 done_c1", int'(bus.done), 1);
      end
      if (bus.busy) busy_seen++;
      if (bus.trigger_pulse) trigs++;
      if (bus.done) dones++;
    end
    check("cnt0 busy_seen", busy_seen, 0);
    check("cnt0 trigs", trigs, 0);
    check("cnt0 done_count", dones, 1);
    check("cnt0 bursts_done", int'(bus.bursts_done), 0);

    // Abort in GAP after burst 2, with an ignored start while busy.
    gen_hold = 6;
    bus.burst_count = 8'd5;
    bus.gap_cycles  = 16'd10;
    bus.duration    = 8'd3;
    bus.start       = 1'b1;
    trigs = 0; t2 = 0;
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 1) bus.start = 1'b0;
      if (bus.trigger_pulse) begin
        trigs++;
        if (trigs == 2) t2 = k;
      end
      if (k == 5) begin
        bus.start       = 1'b1;
        bus.burst_count = 8'd1;
        bus.gap_cycles  = 16'd0;
        bus.duration    = 8'd99;
      end
      if (k == 6) bus.start = 1'b0;
      if (k == 30) begin
        check("abort busy_before", int'(bus.busy), 1);
        bus.abort = 1'b1;
      end
      if (k == 31) bus.abort = 1'b0;
    end
    check("abort trig2_cycle", t2, 19);
    check("abort trigs", trigs, 2);
    check("abort busy", int'(bus.busy), 0);
    check("abort aborted", int'(bus.aborted), 1);
    check("abort done", int'(bus.done), 0);
    check("abort bursts_done", int'(bus.bursts_done), 2);
    check("abort duration_out", int'(bus.duration_out), 3);
    extra_trig = 0; extra_done = 0; extra_ab = 0;
    for (int k = 32; k <= 50; k++) begin
      step();
      if (bus.trigger_pulse) extra_trig++;
      if (bus.done) extra_done++;
      if (bus.aborted) extra_ab++;
    end
    check("abort later_trigs", extra_trig, 0);
    check("abort later_done", extra_done, 0);
    check("abort aborted_1cyc", extra_ab, 0);
    check("abort bursts_hold", int'(bus.bursts_done), 2);

    // abort in the TRIG cycle masks the trigger itself.
    bus.burst_count = 8'd2;
    bus.gap_cycles  = 16'd0;
    bus.duration    = 8'd6;
    bus.start       = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b1;
    #1;
    check("trigabort trigger", int'(bus.trigger_pulse), 0);
    check("trigabort busy", int'(bus.busy), 1);
    step();
    bus.abort = 1'b0;
    check("trigabort aborted", int'(bus.aborted), 1);
    check("trigabort busy_after", int'(bus.busy), 0);
    check("trigabort bursts_done", int'(bus.bursts_done), 0);
    check("trigabort gen_active", int'(bus.gen_active), 0);
    step();
    check("trigabort aborted_1cyc", int'(bus.aborted), 0);
    repeat (2) step();

    // start+abort together in IDLE is a start; then rst during WAIT_DONE.
    bus.burst_count = 8'd2;
    bus.duration    = 8'd12;
    bus.start       = 1'b1;
    bus.abort       = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1;
    check("startabort trigger", int'(bus.trigger_pulse), 1);
    check("startabort busy", int'(bus.busy), 1);
    repeat (3) step();
    check("rstwd gen_active", int'(bus.gen_active), 1);
    check("rstwd busy", int'(bus.busy), 1);
    rst = 1'b1;
    step();
    check_all_zero("rstwd");
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
